// File: rtl/ysyx_23060171_ifu_if.sv
// Fetch-side bus bundle: write-back npc offer, AXI-lite read channel, and the decode handshake.
// Valid/ready rule for every channel here: a transfer happens on a rising edge where both are 1; once valid is raised, payload holds until then.
interface ysyx_23060171_ifu_if;
  logic        npc_valid;
  logic [31:0] npc;
  logic        npc_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        fault;

  modport master (
    input  npc_valid, npc, arready, rdata, rresp, rvalid, inst_ready,
    output npc_ready, araddr, arvalid, rready, inst, pc, inst_valid, fault
  );

  modport slave (
    output npc_valid, npc, arready, rdata, rresp, rvalid, inst_ready,
    input  npc_ready, araddr, arvalid, rready, inst, pc, inst_valid, fault
  );
endinterface

// File: rtl/ysyx_23060171_ifu.sv
// Multi-cycle instruction fetch: one AXI-lite read per instruction, result handed to decode.
// Optional macro YSYX_23060171_IFU_ALIGN_CHK_EN faults misaligned PCs without issuing a read.
module ysyx_23060171_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ysyx_23060171_ifu_if.master        bus,
  output logic [31:0]                fetch_cnt,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_ADDR    = 2'd0,
    S_DATA    = 2'd1,
    S_OUT     = 2'd2,
    S_WAIT_PC = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic [31:0] cnt_q;
  logic        misaligned;

`ifdef YSYX_23060171_IFU_ALIGN_CHK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ADDR;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      case (state_q)
        S_ADDR: begin
          // A misaligned PC skips the bus entirely and reports a fault directly.
          if (misaligned) begin
            inst_q  <= 32'h0;
            fault_q <= 1'b1;
            state_q <= S_OUT;
          end else if (bus.arready) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.rvalid) begin
            inst_q  <= bus.rdata;
            fault_q <= (bus.rresp != 2'b00);
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.inst_ready) begin
            cnt_q   <= cnt_q + 32'd1;
            state_q <= S_WAIT_PC;
          end
        end
        S_WAIT_PC: begin
          if (bus.npc_valid) begin
            pc_q    <= bus.npc;
            state_q <= S_ADDR;
          end
        end
        default: state_q <= S_ADDR;
      endcase
    end
  end

  // Handshake outputs decode only registered state, so no input reaches an output combinationally.
  assign bus.arvalid    = (state_q == S_ADDR) && !misaligned;
  assign bus.rready     = (state_q == S_DATA);
  assign bus.inst_valid = (state_q == S_OUT);
  assign bus.npc_ready  = (state_q == S_WAIT_PC);
  assign bus.araddr     = pc_q;
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.fault      = fault_q;
  assign fetch_cnt      = cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ysyx_23060171_ifu.sv
// Directed bench for the fetch unit: reset, backpressure, address stall, error response, mid-fetch reset, alignment.
module tb_ysyx_23060171_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_cnt;
  logic [1:0]  dbg_state;
  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] exp_inst;

  ysyx_23060171_ifu_if bus ();

  ysyx_23060171_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fetch_cnt (fetch_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one cycle; outputs are then sampled and inputs driven 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.npc_valid  = 1'b0;
    bus.npc        = 32'h0;
    bus.arready    = 1'b0;
    bus.rdata      = 32'h0;
    bus.rresp      = 2'b00;
    bus.rvalid     = 1'b0;
    bus.inst_ready = 1'b0;
  endtask

  // drive one read response and record the expected instruction word
  task automatic give_data(input logic [31:0] d, input logic [1:0] r);
    bus.rvalid = 1'b1;
    bus.rdata  = d;
    bus.rresp  = r;
    exp_q.push_back(d);
  endtask

  task automatic check_out(input string tag, input logic [31:0] epc, input logic efault);
    check({tag, "_valid"}, {31'h0, bus.inst_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_queue got=empty exp=entry", tag);
    end else begin
      exp_inst = exp_q.pop_front();
      check({tag, "_inst"}, bus.inst, exp_inst);
    end
    check({tag, "_pc"}, bus.pc, epc);
    check({tag, "_fault"}, {31'h0, bus.fault}, {31'h0, efault});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    step();
    step();

    // reset values while held in reset
    check("rst_arvalid", {31'h0, bus.arvalid}, 32'd1);
    check("rst_araddr", bus.araddr, RESET_PC);
    check("rst_pc", bus.pc, RESET_PC);
    check("rst_rready", {31'h0, bus.rready}, 32'd0);
    check("rst_inst_valid", {31'h0, bus.inst_valid}, 32'd0);
    check("rst_npc_ready", {31'h0, bus.npc_ready}, 32'd0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_fault", {31'h0, bus.fault}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'h0);

    // first fetch, zero-wait memory
    bus.arready = 1'b1;
    rst_n = 1'b1;
    step();
    check("f1_rready", {31'h0, bus.rready}, 32'd1);
    check("f1_arvalid_low", {31'h0, bus.arvalid}, 32'd0);
    bus.arready = 1'b0;
    give_data(32'h0000_0297, 2'b00);
    step();
    check_out("f1", RESET_PC, 1'b0);
    bus.rvalid = 1'b0;

    // decode backpressure; an npc offer now must be ignored
    bus.npc_valid = 1'b1;
    bus.npc       = 32'h8000_0010;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'h0, bus.inst_valid}, 32'd1);
      check("bp_inst", bus.inst, 32'h0000_0297);
      check("bp_pc", bus.pc, RESET_PC);
      check("bp_fault", {31'h0, bus.fault}, 32'd0);
      check("bp_npc_ready", {31'h0, bus.npc_ready}, 32'd0);
      check("bp_arvalid", {31'h0, bus.arvalid}, 32'd0);
    end
    bus.inst_ready = 1'b1;
    step();
    check("hs1_cnt", fetch_cnt, 32'd1);
    check("hs1_npc_ready", {31'h0, bus.npc_ready}, 32'd1);
    check("hs1_inst_valid", {31'h0, bus.inst_valid}, 32'd0);
    bus.inst_ready = 1'b0;

    // npc accepted (npc_valid still high), then address stalls for 3 cycles
    step();
    bus.npc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_arvalid", {31'h0, bus.arvalid}, 32'd1);
      check("stall_araddr", bus.araddr, 32'h8000_0010);
      check("stall_npc_ready", {31'h0, bus.npc_ready}, 32'd0);
      if (i < 2) step();
    end
    bus.arready = 1'b1;
    step();
    check("f2_rready", {31'h0, bus.rready}, 32'd1);
    bus.arready = 1'b0;

    // error response
    give_data(32'hDEAD_BEEF, 2'b10);
    step();
    check_out("err", 32'h8000_0010, 1'b1);
    bus.rvalid     = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    check("hs2_cnt", fetch_cnt, 32'd2);
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b1;
    bus.npc        = 32'h8000_0014;
    step();
    bus.npc_valid = 1'b0;
    check("f3_araddr", bus.araddr, 32'h8000_0014);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    give_data(32'h0010_0073, 2'b00);
    step();
    check_out("okay", 32'h8000_0014, 1'b0);
    bus.rvalid = 1'b0;

    // reset asserted while waiting for read data
    bus.inst_ready = 1'b1;
    step();
    check("hs3_cnt", fetch_cnt, 32'd3);
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b1;
    bus.npc        = 32'h8000_0018;
    step();
    bus.npc_valid = 1'b0;
    bus.arready   = 1'b1;
    step();
    bus.arready = 1'b0;
    check("pre_rst_rready", {31'h0, bus.rready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rready", {31'h0, bus.rready}, 32'd0);
    check("mid_rst_arvalid", {31'h0, bus.arvalid}, 32'd1);
    check("mid_rst_pc", bus.pc, RESET_PC);
    check("mid_rst_cnt", fetch_cnt, 32'h0);
    check("mid_rst_inst", bus.inst, 32'h0);
    step();
    rst_n = 1'b1;

    // fetch to WAIT_PC, then offer a misaligned PC
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    give_data(32'h0000_0013, 2'b00);
    step();
    check_out("f4", RESET_PC, 1'b0);
    bus.rvalid     = 1'b0;
    bus.inst_ready = 1'b1;
    step();
    check("hs4_cnt", fetch_cnt, 32'd1);
    bus.inst_ready = 1'b0;
    bus.npc_valid  = 1'b1;
    bus.npc        = 32'h8000_0002;
    step();
    bus.npc_valid = 1'b0;
`ifdef YSYX_23060171_IFU_ALIGN_CHK_EN
    check("mis_arvalid", {31'h0, bus.arvalid}, 32'd0);
    step();
    exp_q.push_back(32'h0);
    check_out("mis", 32'h8000_0002, 1'b1);
`else
    check("mis_arvalid", {31'h0, bus.arvalid}, 32'd1);
    check("mis_araddr", bus.araddr, 32'h8000_0002);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
